// File: rtl/rx_driver_pkg.sv
// rtl/rx_driver_pkg.sv - LTSSM state encoding, ordered-set symbol constants and generator modes
package rx_driver_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET             = 4'd0,
    DETECT_ACTIVE            = 4'd1,
    POLLING_ACTIVE           = 4'd2,
    POLLING_ACTIVE_START_TS1 = 4'd3,
    POLLING_CONFIG           = 4'd4,
    CONFIG_LINKWIDTH_START   = 4'd5
  } ltssm_state_e;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_TS1  = 2'd1,
    MODE_TS2  = 2'd2
  } mode_e;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;
  localparam logic [7:0] D2_0   = 8'h02;
  localparam logic [7:0] D4_0   = 8'h04;
  localparam logic [7:0] D8_0   = 8'h08;

endpackage

// File: rtl/rx_driver_if.sv
// rtl/rx_driver_if.sv - PIPE receive symbol bus (rxdata/rxdatak/rxvalid)
interface rx_driver_if;

  logic [7:0] rxdata;
  logic       rxdatak;
  logic       rxvalid;

  modport master (output rxdata, output rxdatak, output rxvalid);
  modport slave  (input  rxdata, input  rxdatak, input  rxvalid);

endinterface

// File: rtl/rx_driver.sv
// rtl/rx_driver.sv - per-lane TS1/TS2 ordered-set generator driven by the LTSSM state
module rx_driver
  import rx_driver_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  ost_i,
  input  logic        en_n_i,
  input  logic [39:0] ts1_i,
  input  logic [39:0] ts2_i,
  rx_driver_if.master rx_o
);

  mode_e       mode_q, mode_d;
  logic [3:0]  sym_idx_q, sym_idx_d;
  logic [39:0] cfg_q, cfg_d;
  logic [7:0]  rxdata_q, rxdata_d;
  logic        rxdatak_q, rxdatak_d;
  logic        rxvalid_q, rxvalid_d;
  logic [3:0]  idx;
  logic [39:0] cfg_src;

  // Undefined encodings fall through to IDLE along with every non-training state.
  always_comb begin
    mode_d = MODE_IDLE;
    if (!en_n_i) begin
      case (ost_i)
        POLLING_ACTIVE_START_TS1,
        CONFIG_LINKWIDTH_START: mode_d = MODE_TS1;
        POLLING_CONFIG:         mode_d = MODE_TS2;
        default:                mode_d = MODE_IDLE;
      endcase
    end
  end

  // A mode switch restarts the set at COM; config is sampled only as COM goes out.
  always_comb begin
    idx       = (mode_d != mode_q) ? 4'd0 : sym_idx_q;
    cfg_src   = (mode_d == MODE_TS2) ? ts2_i : ts1_i;
    sym_idx_d = 4'd0;
    cfg_d     = cfg_q;
    rxdata_d  = 8'h00;
    rxdatak_d = 1'b0;
    rxvalid_d = 1'b0;
    if (mode_d != MODE_IDLE) begin
      sym_idx_d = idx + 4'd1;
      rxvalid_d = 1'b1;
      case (idx)
        4'd0: begin
          rxdata_d  = COM;
          rxdatak_d = 1'b1;
          cfg_d     = cfg_src;
        end
        4'd1: begin
          rxdata_d  = cfg_q[7:0];
          rxdatak_d = (cfg_q[7:0] == PAD);
        end
        4'd2: begin
          rxdata_d  = cfg_q[15:8];
          rxdatak_d = (cfg_q[15:8] == PAD);
        end
        4'd3:    rxdata_d = cfg_q[23:16];
        4'd4:    rxdata_d = cfg_q[31:24];
        4'd5:    rxdata_d = cfg_q[39:32];
        default: rxdata_d = (mode_d == MODE_TS2) ? TS2_ID : TS1_ID;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mode_q    <= MODE_IDLE;
      sym_idx_q <= 4'd0;
      cfg_q     <= 40'd0;
      rxdata_q  <= 8'h00;
      rxdatak_q <= 1'b0;
      rxvalid_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      sym_idx_q <= sym_idx_d;
      cfg_q     <= cfg_d;
      rxdata_q  <= rxdata_d;
      rxdatak_q <= rxdatak_d;
      rxvalid_q <= rxvalid_d;
    end
  end

  assign rx_o.rxdata  = rxdata_q;
  assign rx_o.rxdatak = rxdatak_q;
  assign rx_o.rxvalid = rxvalid_q;

endmodule

// File: tb/tb_rx_driver.sv
// tb/tb_rx_driver.sv - directed-vector bench for rx_driver
module tb_rx_driver;
  import rx_driver_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ost;
  logic        en_n;
  logic [39:0] ts1;
  logic [39:0] ts2;

  rx_driver_if rx();

  rx_driver dut (
    .clk_i   (clk),
    .reset_i (reset),
    .ost_i   (ost),
    .en_n_i  (en_n),
    .ts1_i   (ts1),
    .ts2_i   (ts2),
    .rx_o    (rx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // {rxvalid, rxdatak, rxdata}
  localparam logic [9:0] ZERO = 10'h000;
  logic [9:0] tab1 [16];
  logic [9:0] tab1b[16];
  logic [9:0] tab2 [16];

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step_chk(input string tag, input logic [9:0] exp);
    @(posedge clk);
    #1;
    check(tag, {rx.rxvalid, rx.rxdatak, rx.rxdata}, exp);
  endtask

  task automatic run_set(input string tag, input int which, input int first, input int cnt);
    int s;
    logic [9:0] e;
    for (int i = 0; i < cnt; i++) begin
      s = (first + i) % 16;
      e = (which == 0) ? tab1[s] : (which == 1) ? tab1b[s] : tab2[s];
      step_chk($sformatf("%s_s%0d", tag, s), e);
    end
  endtask

  initial begin
    tab1[0] = 10'h3BC; tab1[1] = 10'h3F7; tab1[2] = 10'h3F7;
    tab1[3] = 10'h204; tab1[4] = 10'h202; tab1[5] = 10'h208;
    tab1b[0] = 10'h3BC; tab1b[1] = 10'h3F7; tab1b[2] = 10'h203;
    tab1b[3] = 10'h204; tab1b[4] = 10'h202; tab1b[5] = 10'h208;
    tab2[0] = 10'h3BC; tab2[1] = 10'h201; tab2[2] = 10'h205;
    tab2[3] = 10'h220; tab2[4] = 10'h206; tab2[5] = 10'h210;
    for (int i = 6; i < 16; i++) begin
      tab1[i]  = 10'h24A;
      tab1b[i] = 10'h24A;
      tab2[i]  = 10'h245;
    end

    reset = 1'b1;
    ost   = POLLING_ACTIVE_START_TS1;
    en_n  = 1'b0;
    ts1   = {D8_0, D2_0, D4_0, PAD, PAD};
    ts2   = {8'h10, 8'h06, 8'h20, 8'h05, 8'h01};
    for (int i = 0; i < 3; i++) step_chk("reset", ZERO);

    reset = 1'b0;
    run_set("ts1", 0, 0, 32);

    // Switch to TS2 while sym7 is on the bus
    run_set("ts1c", 0, 0, 8);
    ost = POLLING_CONFIG;
    run_set("ts2", 2, 0, 16);
    run_set("ts2b", 2, 0, 5);

    en_n = 1'b1;
    step_chk("elecidle0", ZERO);
    step_chk("elecidle1", ZERO);
    en_n = 1'b0;
    run_set("reen", 2, 0, 3);

    ost = DETECT_QUIET;
    for (int i = 0; i < 3; i++) step_chk("detect", ZERO);
    ost = 4'hF;
    for (int i = 0; i < 2; i++) step_chk("bad_ost", ZERO);

    // Lane byte changes mid-set; same-mode state change must not restart the set
    ost = CONFIG_LINKWIDTH_START;
    run_set("cfglw", 0, 0, 2);
    ts1[15:8] = 8'h03;
    ost = POLLING_ACTIVE_START_TS1;
    run_set("hold", 0, 2, 14);
    run_set("newlane", 1, 0, 11);

    reset = 1'b1;
    step_chk("rst_mid", ZERO);
    reset = 1'b0;
    run_set("rst_resume", 1, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
